// File: rtl/sweep_chk_pkg.sv
// Shared types and default constants for the sweep response checker.
package sweep_chk_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StSettle,
        StSample,
        StDone
    } chk_state_e;

    localparam int unsigned CHK_WIDTH    = 5;
    localparam logic [15:0] CHK_SIG_POLY = 16'h1021;
    localparam logic [15:0] CHK_SIG_SEED = 16'hFFFF;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: shift left, fold in polynomial on MSB, XOR data.
module misr_reg #(
    parameter int unsigned          SIG_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY  = 16'h1021,
    parameter logic [SIG_WIDTH-1:0] SIG_SEED  = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic                 en,
    input  logic [SIG_WIDTH-1:0] data_in,
    output logic [SIG_WIDTH-1:0] sig
);

    logic [SIG_WIDTH-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (init) begin
            sig_d = SIG_SEED;
        end else if (en) begin
            sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0}
                  ^ (sig_q[SIG_WIDTH-1] ? SIG_POLY : '0)
                  ^ data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SIG_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/sweep_response_checker.sv
// Checks DUT responses over an exhaustive code sweep: settle, sample, compare, track coverage,
// count mismatches, capture the first failing code and compress responses into a MISR.
module sweep_response_checker
    import sweep_chk_pkg::*;
#(
    parameter int unsigned          WIDTH         = CHK_WIDTH,
    parameter int unsigned          SETTLE_CYCLES = 3,
    parameter int unsigned          SIG_WIDTH     = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY      = CHK_SIG_POLY,
    parameter logic [SIG_WIDTH-1:0] SIG_SEED      = CHK_SIG_SEED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 vec_valid,
    output logic                 vec_ready,
    input  logic [WIDTH-1:0]     vec_code,
    input  logic [WIDTH-1:0]     exp_out,
    input  logic [WIDTH-1:0]     dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [5:0]           err_count,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     first_err_code,
    output logic [7:0]           sample_count,
    output logic [SIG_WIDTH-1:0] signature
);

    localparam int unsigned NumCodes   = 1 << WIDTH;
    localparam logic [3:0]  SettleLoad = 4'(SETTLE_CYCLES - 1);

    chk_state_e state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]    code_q, code_d;
    logic [WIDTH-1:0]    exp_q, exp_d;
    logic [5:0]          err_q, err_d;
    logic                fev_q, fev_d;
    logic [WIDTH-1:0]    fec_q, fec_d;
    logic [7:0]          sc_q, sc_d;
    logic [NumCodes-1:0] bitmap_q, bitmap_d;
    logic                misr_init, misr_en;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        exp_d     = exp_q;
        err_d     = err_q;
        fev_d     = fev_q;
        fec_d     = fec_q;
        sc_d      = sc_q;
        bitmap_d  = bitmap_q;
        misr_init = 1'b0;
        misr_en   = 1'b0;

        // start wins from every state, aborting any vector in flight
        if (start) begin
            state_d   = StArmed;
            cnt_d     = '0;
            err_d     = '0;
            fev_d     = 1'b0;
            fec_d     = '0;
            sc_d      = '0;
            bitmap_d  = '0;
            misr_init = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: ;
                StArmed: begin
                    if (vec_valid) begin
                        code_d  = vec_code;
                        exp_d   = exp_out;
                        cnt_d   = SettleLoad;
                        state_d = StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q == 4'd0) begin
                        state_d = StSample;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StSample: begin
                    if (dut_out != exp_q) begin
                        if (err_q != 6'd63) begin
                            err_d = err_q + 6'd1;
                        end
                        if (!fev_q) begin
                            fev_d = 1'b1;
                            fec_d = code_q;
                        end
                    end
                    if (sc_q != 8'd255) begin
                        sc_d = sc_q + 8'd1;
                    end
                    bitmap_d[code_q] = 1'b1;
                    misr_en          = 1'b1;
                    state_d          = (&bitmap_d) ? StDone : StArmed;
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            code_q   <= '0;
            exp_q    <= '0;
            err_q    <= '0;
            fev_q    <= 1'b0;
            fec_q    <= '0;
            sc_q     <= '0;
            bitmap_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            fev_q    <= fev_d;
            fec_q    <= fec_d;
            sc_q     <= sc_d;
            bitmap_q <= bitmap_d;
        end
    end

    misr_reg #(
        .SIG_WIDTH (SIG_WIDTH),
        .SIG_POLY  (SIG_POLY),
        .SIG_SEED  (SIG_SEED)
    ) u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (misr_init),
        .en      (misr_en),
        .data_in (SIG_WIDTH'({code_q, dut_out})),
        .sig     (signature)
    );

    assign vec_ready       = (state_q == StArmed);
    assign busy            = (state_q == StArmed) || (state_q == StSettle)
                          || (state_q == StSample);
    assign done            = (state_q == StDone);
    assign pass            = done && (err_q == 6'd0);
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_code  = fec_q;
    assign sample_count    = sc_q;

endmodule

// File: tb/tb_sweep_response_checker.sv
// Randomized scoreboard bench for sweep_response_checker with a behavioural reference model.
module tb_sweep_response_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic       vec_ready;
    logic [4:0] vec_code = '0;
    logic [4:0] exp_out = '0;
    logic [4:0] dut_out = '0;
    logic       busy, done, pass;
    logic [5:0] err_count;
    logic       first_err_valid;
    logic [4:0] first_err_code;
    logic [7:0] sample_count;
    logic [15:0] signature;

    sweep_response_checker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .vec_valid       (vec_valid),
        .vec_ready       (vec_ready),
        .vec_code        (vec_code),
        .exp_out         (exp_out),
        .dut_out         (dut_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_code  (first_err_code),
        .sample_count    (sample_count),
        .signature       (signature)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  err;
        logic        fev;
        logic [4:0]  fec;
        logic [7:0]  sc;
        logic [15:0] sig;
        logic        done;
        logic        pass;
    } result_t;

    result_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          m_err, m_sc, m_ncov;
    bit          m_fev;
    logic [4:0]  m_fec;
    int          m_sig;
    bit          m_cov[32];
    logic [4:0]  order[32];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic int misr_next(input int sig, input int data);
        int s;
        s = (sig * 2) % 65536;
        if (sig >= 32768) s = s ^ 'h1021;
        return s ^ data;
    endfunction

    task automatic model_reset();
        m_err = 0; m_sc = 0; m_ncov = 0; m_fev = 0; m_fec = '0; m_sig = 'hFFFF;
        for (int i = 0; i < 32; i++) m_cov[i] = 0;
        sb.delete();
    endtask

    task automatic model_sample(input logic [4:0] code, input logic [4:0] ev, input logic [4:0] dv);
        result_t e;
        if (dv != ev) begin
            if (m_err < 63) m_err++;
            if (!m_fev) begin m_fev = 1; m_fec = code; end
        end
        if (m_sc < 255) m_sc++;
        if (!m_cov[code]) begin m_cov[code] = 1; m_ncov++; end
        m_sig = misr_next(m_sig, int'(code) * 32 + int'(dv));
        e.err  = 6'(m_err);
        e.fev  = m_fev;
        e.fec  = m_fec;
        e.sc   = 8'(m_sc);
        e.sig  = 16'(m_sig);
        e.done = (m_ncov == 32);
        e.pass = (m_ncov == 32) && (m_err == 0);
        sb.push_back(e);
    endtask

    // monitor: every sample_count step is one presented result
    int prev_sc = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sc = 0;
        end else if (int'(sample_count) != prev_sc) begin
            if (sample_count != 8'd0) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sample_count), 64'(0));
                end else begin
                    check("result", 64'({err_count, first_err_valid, first_err_code, sample_count,
                                         signature, done, pass}), 64'(sb.pop_front()));
                end
            end
            prev_sc = int'(sample_count);
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_reset();
    endtask

    // Apply one vector; dut_out glitches during settle and holds dv from the 2nd settle clock.
    task automatic apply(input logic [4:0] code, input logic [4:0] ev, input logic [4:0] dv,
                         input bit poke9);
        int n = 0;
        int lat = 0;
        while (!vec_ready && n < 50) begin @(negedge clk); n++; end
        check("ready_wait", 64'(vec_ready), 64'(1));
        vec_valid = 1'b1; vec_code = code; exp_out = ev; dut_out = 5'($urandom);
        model_sample(code, ev, dv);
        forever begin
            @(negedge clk);
            if (vec_ready || done || lat > 20) break;
            lat++;
            if (lat == 1) begin
                vec_valid = poke9; vec_code = 5'd9; exp_out = 5'($urandom);
                dut_out = 5'($urandom);
            end else if (lat == 2) begin
                vec_valid = 1'b0; dut_out = dv;
            end
        end
        vec_valid = 1'b0;
        check("latency", 64'(lat), 64'(4));
    endtask

    function automatic logic [4:0] wrong(input logic [4:0] v);
        return v ^ 5'($urandom_range(1, 31));
    endfunction

    task automatic shuffle();
        for (int i = 0; i < 32; i++) order[i] = 5'(i);
        for (int i = 31; i > 0; i--) begin
            int j;
            logic [4:0] t;
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] ev;
        int k;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({vec_ready, busy, done, pass, err_count, first_err_valid,
                                  first_err_code, sample_count}), 64'(0));
        check("rst_sig", 64'(signature), 64'(16'hFFFF));
        rst_n = 1'b1;
        vec_valid = 1'b1;
        repeat (2) @(negedge clk);
        vec_valid = 1'b0;
        check("idle_ignores_vec", 64'({busy, sample_count}), 64'(0));

        // single vector
        do_start();
        check("armed_ready", 64'({vec_ready, busy}), 64'(2'b11));
        apply(5'd0, 5'd0, 5'd0, 1'b0);
        check("t1_err", 64'(err_count), 64'(0));
        check("t1_sc", 64'(sample_count), 64'(1));
        check("t1_sig", 64'(signature), 64'(16'hEFDF));

        // clean full sweep
        do_start();
        for (int c = 0; c < 32; c++) begin
            ev = 5'($urandom);
            if (c == 31) check("t2_not_done_early", 64'(done), 64'(0));
            apply(5'(c), ev, ev, 1'b0);
        end
        check("t2_flags", 64'({done, pass, busy}), 64'(3'b110));
        check("t2_err", 64'(err_count), 64'(0));
        check("t2_sc", 64'(sample_count), 64'(32));
        vec_valid = 1'b1; vec_code = 5'd1;
        repeat (3) @(negedge clk);
        vec_valid = 1'b0;
        check("t2_done_holds", 64'({done, sample_count}), 64'({1'b1, 8'd32}));

        // errors on 5 and 17
        do_start();
        for (int c = 0; c < 32; c++) begin
            ev = 5'($urandom);
            apply(5'(c), ev, (c == 5 || c == 17) ? wrong(ev) : ev, 1'b0);
        end
        check("t3_err", 64'(err_count), 64'(2));
        check("t3_first", 64'({first_err_valid, first_err_code}), 64'({1'b1, 5'd5}));
        check("t3_flags", 64'({done, pass}), 64'(2'b10));

        // duplicate code 3, random order, sparse random errors
        do_start();
        shuffle();
        ev = 5'($urandom);
        apply(5'd3, ev, ev, 1'b0);
        ev = 5'($urandom);
        apply(5'd3, ev, ev, 1'b0);
        k = 0;
        for (int i = 0; i < 32; i++) begin
            if (order[i] == 5'd3) continue;
            k++;
            if (k == 31) check("t4_not_done_early", 64'(done), 64'(0));
            ev = 5'($urandom);
            apply(order[i], ev, ($urandom_range(0, 7) == 0) ? wrong(ev) : ev, 1'b0);
        end
        check("t4_sc", 64'(sample_count), 64'(33));
        check("t4_done", 64'(done), 64'(1));

        // code 9 offered during settle must be ignored
        do_start();
        shuffle();
        k = 0;
        for (int i = 0; i < 32; i++) begin
            if (order[i] == 5'd9) continue;
            ev = 5'($urandom);
            apply(order[i], ev, ev, (k == 0));
            k++;
        end
        check("t5_not_done", 64'({done, sample_count}), 64'({1'b0, 8'd31}));
        ev = 5'($urandom);
        apply(5'd9, ev, ev, 1'b0);
        check("t5_done", 64'({done, pass}), 64'(2'b11));

        // async reset mid-settle
        do_start();
        apply(5'd4, 5'd1, 5'd2, 1'b0);
        vec_valid = 1'b1; vec_code = 5'd6; exp_out = 5'd6;
        @(negedge clk);
        vec_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", 64'({vec_ready, busy, done, pass, err_count, first_err_valid,
                                     first_err_code, sample_count}), 64'(0));
        check("t6_rst_sig", 64'(signature), 64'(16'hFFFF));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // start mid-settle aborts and re-arms
        do_start();
        apply(5'd7, 5'd3, 5'd0, 1'b0);
        apply(5'd8, 5'd3, 5'd3, 1'b0);
        vec_valid = 1'b1; vec_code = 5'd10; exp_out = 5'd0;
        @(negedge clk);
        vec_valid = 1'b0;
        do_start();
        check("t7_ready", 64'({vec_ready, busy}), 64'(2'b11));
        check("t7_cleared", 64'({err_count, first_err_valid, sample_count}), 64'(0));
        check("t7_sig", 64'(signature), 64'(16'hFFFF));
        apply(5'd11, 5'd2, 5'd2, 1'b0);
        check("t7_sc", 64'(sample_count), 64'(1));

        repeat (10) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
